// File: rtl/pipe_pkg.sv
// Shared definitions for the inter-stage transfer chain: default Riscv151
// payload layout, the NOP encoding and a popcount helper.
package pipe_pkg;

  localparam logic [31:0] RV_NOP = 32'h0000_0013;

  localparam int PC_W   = 32;
  localparam int RS1D_W = 32;
  localparam int RS2D_W = 32;
  localparam int IMM_W  = 32;
  localparam int INST_W = 32;

  localparam int INST_LSB  = 0;
  localparam int IMM_LSB   = INST_LSB + INST_W;
  localparam int RS2D_LSB  = IMM_LSB + IMM_W;
  localparam int RS1D_LSB  = RS2D_LSB + RS2D_W;
  localparam int PC_LSB    = RS1D_LSB + RS1D_W;
  localparam int PAYLOAD_W = PC_LSB + PC_W;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [RS1D_W-1:0] rs1d;
    logic [RS2D_W-1:0] rs2d;
    logic [IMM_W-1:0]  imm;
    logic [INST_W-1:0] inst;
  } stage_payload_t;

  // Widest valid vector popcount accepts; chains deeper than this are unsupported.
  localparam int POP_MAX = 64;

  function automatic int unsigned popcount(input logic [POP_MAX-1:0] v);
    int unsigned cnt;
    cnt = 0;
    for (int i = 0; i < POP_MAX; i++) cnt += 32'(v[i]);
    return cnt;
  endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// One chain stage: valid bit plus payload. Advancing loads the source entry
// (BUBBLE when it is not valid); a kill without advance clears in place.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                WIDTH  = 160,
  parameter logic [WIDTH-1:0]  BUBBLE = '0
) (
  input  logic             gclk,
  input  logic             grst_n,
  input  logic             adv,
  input  logic             kill,
  input  logic             ld_v,
  input  logic [WIDTH-1:0] ld_d,
  output logic             v,
  output logic [WIDTH-1:0] d
);

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      v <= 1'b0;
      d <= BUBBLE;
    end else if (adv) begin
      v <= ld_v;
      d <= ld_v ? ld_d : BUBBLE;
    end else if (kill) begin
      v <= 1'b0;
      d <= BUBBLE;
    end
  end

endmodule

// File: rtl/pipe_stage_chain.sv
// DEPTH-deep transfer chain with per-stage kill, global stall and either
// elastic valid/ready bubble collapsing or lockstep shifting.
module pipe_stage_chain
  import pipe_pkg::*;
#(
  parameter int               WIDTH   = 160,
  parameter int               DEPTH   = 1,
  parameter bit               ELASTIC = 1'b1,
  parameter logic [WIDTH-1:0] BUBBLE  = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       stall,
  input  logic [DEPTH-1:0]           kill,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int OCC_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0]            vld_pipe, adv, ld_v, v_nxt;
  logic [DEPTH-1:0][WIDTH-1:0] dat, ld_d;
  logic                        room;
  logic [POP_MAX-1:0]          v_nxt_ext;

  // room = some slot at or downstream of stage i frees up this cycle
  always_comb begin
    adv  = '0;
    room = 1'b0;
    if (ELASTIC) begin
      room           = ~vld_pipe[DEPTH-1] | out_ready | kill[DEPTH-1];
      adv[DEPTH-1]   = ~stall & room;
      for (int i = DEPTH - 2; i >= 0; i--) begin
        room   = room | ~vld_pipe[i] | kill[i];
        adv[i] = ~stall & room;
      end
    end else begin
      adv = {DEPTH{~stall}};
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    if (g == 0) begin : g_head
      assign ld_v[g] = in_valid;
      assign ld_d[g] = in_data;
    end else begin : g_link
      assign ld_v[g] = vld_pipe[g-1] & ~kill[g-1] & adv[g-1];
      assign ld_d[g] = dat[g-1];
    end

    assign v_nxt[g] = adv[g] ? ld_v[g] : (vld_pipe[g] & ~kill[g]);

    pipe_stage_reg #(
      .WIDTH  (WIDTH),
      .BUBBLE (BUBBLE)
    ) u_stage (
      .gclk   (clk),
      .grst_n (reset),
      .adv    (adv[g]),
      .kill   (kill[g]),
      .ld_v   (ld_v[g]),
      .ld_d   (ld_d[g]),
      .v      (vld_pipe[g]),
      .d      (dat[g])
    );
  end

  // Counting the next valid vector keeps occupancy exact under any mix of
  // accept, drain and kill, including entries killed while moving.
  always_comb begin
    v_nxt_ext              = '0;
    v_nxt_ext[DEPTH-1:0]   = v_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) occupancy <= '0;
    else        occupancy <= OCC_W'(popcount(v_nxt_ext));
  end

  assign in_ready  = adv[0] & reset;
  assign out_valid = vld_pipe[DEPTH-1];
  assign out_data  = dat[DEPTH-1];

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Drives an elastic DEPTH=3 chain, a lockstep DEPTH=1 chain and a lockstep
// DEPTH=3 chain from shared inputs and checks them against a slot-level model.
module tb_pipe_stage_chain;
  import pipe_pkg::*;

  localparam int W = 32;
  localparam int D = 3;
  localparam logic [W-1:0] BUB_A = RV_NOP;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         stall = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [D-1:0] kill = '0;
  logic [W-1:0] in_data = '0;

  logic a_ir, a_ov, b_ir, b_ov, c_ir, c_ov;
  logic [W-1:0] a_od, b_od, c_od;
  logic [1:0] a_occ, c_occ;
  logic [0:0] b_occ;

  int checks = 0;
  int errors = 0;

  // model state: one valid flag and payload per slot
  logic         ma_v[D];
  logic [W-1:0] ma_d[D];
  logic         mc_v[D];
  logic [W-1:0] mc_d[D];
  logic         mb_v;
  logic [W-1:0] mb_d;

  always #5 clk = ~clk;

  pipe_stage_chain #(.WIDTH(W), .DEPTH(D), .ELASTIC(1'b1), .BUBBLE(BUB_A)) dut_a (
    .clk(clk), .reset(rst_n), .stall(stall), .kill(kill), .in_valid(in_valid),
    .in_ready(a_ir), .in_data(in_data), .out_valid(a_ov), .out_ready(out_ready),
    .out_data(a_od), .occupancy(a_occ));

  pipe_stage_chain #(.WIDTH(W), .DEPTH(1), .ELASTIC(1'b0), .BUBBLE('0)) dut_b (
    .clk(clk), .reset(rst_n), .stall(stall), .kill(kill[0:0]), .in_valid(in_valid),
    .in_ready(b_ir), .in_data(in_data), .out_valid(b_ov), .out_ready(out_ready),
    .out_data(b_od), .occupancy(b_occ));

  pipe_stage_chain #(.WIDTH(W), .DEPTH(D), .ELASTIC(1'b0), .BUBBLE('0)) dut_c (
    .clk(clk), .reset(rst_n), .stall(stall), .kill(kill), .in_valid(in_valid),
    .in_ready(c_ir), .in_data(in_data), .out_valid(c_ov), .out_ready(out_ready),
    .out_data(c_od), .occupancy(c_occ));

  // entry in slot i still present after kills and this cycle's delivery
  function automatic logic a_keep(int i);
    return ma_v[i] && !kill[i] && !(i == D-1 && !stall && out_ready);
  endfunction

  function automatic logic a_free_from(int j);
    logic f;
    f = 1'b0;
    for (int k = j; k < D; k++) if (!a_keep(k)) f = 1'b1;
    return f;
  endfunction

  // elastic: every entry steps forward one slot if any slot ahead opens up
  function automatic logic [W:0] a_next(int i);
    if (stall) return a_keep(i) ? {1'b1, ma_d[i]} : {1'b0, BUB_A};
    if (a_keep(i) && (i == D-1 || !a_free_from(i+1))) return {1'b1, ma_d[i]};
    if (i > 0 && a_keep(i-1) && a_free_from(i)) return {1'b1, ma_d[i-1]};
    if (i == 0 && in_valid && a_free_from(0)) return {1'b1, in_data};
    return {1'b0, BUB_A};
  endfunction

  function automatic logic [W:0] c_next(int i);
    if (stall) return (mc_v[i] && !kill[i]) ? {1'b1, mc_d[i]} : '0;
    if (i == 0) return in_valid ? {1'b1, in_data} : '0;
    return (mc_v[i-1] && !kill[i-1]) ? {1'b1, mc_d[i-1]} : '0;
  endfunction

  function automatic int cnt(logic v[D]);
    int n;
    n = 0;
    for (int i = 0; i < D; i++) n += int'(v[i]);
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < D; i++) begin
        ma_v[i] <= 1'b0; ma_d[i] <= BUB_A;
        mc_v[i] <= 1'b0; mc_d[i] <= '0;
      end
      mb_v <= 1'b0; mb_d <= '0;
    end else begin
      for (int i = 0; i < D; i++) begin
        {ma_v[i], ma_d[i]} <= a_next(i);
        {mc_v[i], mc_d[i]} <= c_next(i);
      end
      if (stall) begin
        if (kill[0]) begin mb_v <= 1'b0; mb_d <= '0; end
      end else begin
        mb_v <= in_valid;
        mb_d <= in_valid ? in_data : '0;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp_all();
    logic rdy;
    rdy = rst_n && !stall;
    chk("a_out_valid", 32'(a_ov), 32'(ma_v[D-1]));
    chk("a_out_data",  a_od, ma_d[D-1]);
    chk("a_occupancy", 32'(a_occ), cnt(ma_v));
    chk("a_in_ready",  32'(a_ir), 32'(rdy && a_free_from(0)));
    chk("b_out_valid", 32'(b_ov), 32'(mb_v));
    chk("b_out_data",  b_od, mb_d);
    chk("b_occupancy", 32'(b_occ), 32'(mb_v));
    chk("b_in_ready",  32'(b_ir), 32'(rdy));
    chk("c_out_valid", 32'(c_ov), 32'(mc_v[D-1]));
    chk("c_out_data",  c_od, mc_d[D-1]);
    chk("c_occupancy", 32'(c_occ), cnt(mc_v));
    chk("c_in_ready",  32'(c_ir), 32'(rdy));
  endtask

  // compare at the falling edge, then step past the next rising edge
  task automatic cyc();
    @(negedge clk);
    cmp_all();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [W-1:0] x);
    in_valid = 1'b1; in_data = x;
    cyc();
    in_valid = 1'b0;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (2) cyc();
    chk("rst_out_valid", 32'(a_ov), 0);
    chk("rst_out_data", a_od, BUB_A);
    chk("rst_occupancy", 32'(a_occ), 0);
    chk("rst_in_ready", 32'(a_ir), 0);
    rst_n = 1'b1;

    // latency and throughput; lockstep chain shows each entry one cycle later
    out_ready = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      in_valid = (k <= 8); in_data = k; #1;
      chk("lat_in_ready", 32'(a_ir), 1);
      if (k >= 4) begin
        chk("lat_out_valid", 32'(a_ov), 1);
        chk("lat_out_data", a_od, 32'(k - 3));
      end else chk("lat_out_empty", 32'(a_ov), 0);
      if (k >= 2 && k <= 9) chk("lock_out_data", b_od, 32'(k - 1));
      if (k == 10) begin
        chk("lock_bubble_valid", 32'(b_ov), 0);
        chk("lock_bubble_data", b_od, 0);
      end
      cyc();
    end
    in_valid = 1'b0;

    out_ready = 1'b0;
    push(32'h55); #1;
    chk("lock_x_valid", 32'(b_ov), 1);
    chk("lock_x_data", b_od, 32'h55);
    cyc();
    chk("lock_x_gone_valid", 32'(b_ov), 0);
    chk("lock_x_gone_data", b_od, 0);
    out_ready = 1'b1;
    repeat (3) cyc();
    chk("drain_occ", 32'(a_occ), 0);

    // backpressure then same-cycle drain and accept
    out_ready = 1'b0;
    push(32'hA); push(32'hB); push(32'hC);
    chk("full_occ", 32'(a_occ), 3);
    chk("model_full_occ", cnt(ma_v), 3);
    in_valid = 1'b1; in_data = 32'hD; #1;
    chk("full_in_ready", 32'(a_ir), 0);
    out_ready = 1'b1; #1;
    chk("collapse_in_ready", 32'(a_ir), 1);
    chk("collapse_out_data", a_od, 32'hA);
    cyc();
    in_valid = 1'b0; out_ready = 1'b0; #1;
    chk("collapse_occ", 32'(a_occ), 3);
    chk("collapse_next", a_od, 32'hB);

    // kill two younger stages
    kill = 3'b011;
    cyc();
    kill = '0;
    chk("kill_occ", 32'(a_occ), 1);
    chk("kill_out_data", a_od, 32'hB);
    chk("model_kill_occ", cnt(ma_v), 1);
    out_ready = 1'b1;
    cyc();
    chk("kill_drained", 32'(a_ov), 0);
    chk("kill_bubble", a_od, BUB_A);
    cyc();
    chk("kill_none_left", 32'(a_occ), 0);

    // kill while stalled
    out_ready = 1'b0;
    push(32'hE); push(32'hF); push(32'h10);
    stall = 1'b1; kill = 3'b011; out_ready = 1'b1;
    cyc();
    kill = '0;
    chk("skill_occ", 32'(a_occ), 1);
    chk("skill_out_data", a_od, 32'hE);
    cyc();
    chk("skill_unmoved", a_od, 32'hE);
    stall = 1'b0;
    cyc();
    chk("skill_drained", 32'(a_occ), 0);

    // stall with chain half full
    out_ready = 1'b0;
    push(32'h21); push(32'h22);
    cyc();
    chk("half_occ", 32'(a_occ), 2);
    stall = 1'b1; in_valid = 1'b1; in_data = 32'h23; out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1 chk("stall_in_ready", 32'(a_ir), 0);
      cyc();
      chk("stall_occ", 32'(a_occ), 2);
      chk("stall_out_data", a_od, 32'h21);
    end
    stall = 1'b0; in_valid = 1'b0;
    repeat (3) cyc();

    // asynchronous reset mid-stream
    out_ready = 1'b0;
    push(32'h31); push(32'h32); #1;
    chk("pre_rst_occ", 32'(a_occ), 2);
    rst_n = 1'b0; #1;
    chk("async_out_valid", 32'(a_ov), 0);
    chk("async_occ", 32'(a_occ), 0);
    chk("async_out_data", a_od, BUB_A);
    chk("async_in_ready", 32'(a_ir), 0);
    cyc();
    rst_n = 1'b1;

    // randomized traffic
    for (int n = 0; n < 2000; n++) begin
      stall     = ($urandom_range(4) == 0);
      in_valid  = ($urandom_range(9) < 7);
      in_data   = $urandom;
      out_ready = ($urandom_range(9) < 6);
      for (int j = 0; j < D; j++) kill[j] = ($urandom_range(15) == 0);
      if (n == 1000) begin #2 rst_n = 1'b0; #1; end
      cyc();
      if (n == 1000) rst_n = 1'b1;
    end
    stall = 1'b0; kill = '0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
